// File: rtl/cache_arb_pkg.sv
// Shared types for the data-cache arbiter: FSM states, owner tags and the
// latched request record. Record fields are sized for the widest configuration.
package cache_arb_pkg;

  localparam int unsigned CA_ADDR_W = 64;
  localparam int unsigned CA_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  typedef struct packed {
    logic                 op_read;
    logic [CA_ADDR_W-1:0] addr;
    logic [CA_DATA_W-1:0] wdata;
    logic [7:0]           shifter;
    logic [7:0]           dwhb;
    owner_t               owner;
  } cache_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. req[0]/grant[0] is the IFU, req[1]/grant[1] the LSU;
// prio names the requester that wins a tie and flips to the loser on every grant.
module rr_arb2
  import cache_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  owner_t prio;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (prio == OWN_LSU) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= OWN_LSU;
    end else if (advance && (grant != 2'b00)) begin
      prio <= grant[1] ? OWN_IFU : OWN_LSU;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates IFU and LSU requests onto the single-ported data cache, one
// request in flight, and steers the cache result pulse back to its owner.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_resp_data,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_op_read,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [7:0]            lsu_write_shifter,
  input  logic [7:0]            lsu_write_DWHB,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_resp_data,
  output logic                  cache_valid,
  input  logic                  cache_ready,
  output logic                  cache_op_read,
  output logic [ADDR_WIDTH-1:0] cache_read_address,
  output logic [ADDR_WIDTH-1:0] cache_write_address,
  output logic [DATA_WIDTH-1:0] cache_write_data,
  output logic [7:0]            cache_write_shifter,
  output logic [7:0]            cache_write_DWHB,
  input  logic                  cache_out_valid,
  input  logic [DATA_WIDTH-1:0] cache_data
);

  arb_state_t state, state_next;
  cache_req_t req_q, req_d;
  logic       req_load;
  logic       advance;
  logic [1:0] grant;
  logic [7:0] ignore_count;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     ({lsu_req_valid, ifu_req_valid}),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    state_next     = state;
    advance        = 1'b0;
    req_load       = 1'b0;
    req_d          = '0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    cache_valid    = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_resp_data  = '0;
    lsu_resp_data  = '0;
    case (state)
      IDLE: begin
        if ((ifu_req_valid || lsu_req_valid) && cache_ready) begin
          advance    = 1'b1;
          req_load   = 1'b1;
          state_next = ISSUE;
          if (grant[1]) begin
            lsu_req_ready = 1'b1;
            req_d.op_read = lsu_op_read;
            req_d.addr    = CA_ADDR_W'(lsu_addr);
            req_d.wdata   = CA_DATA_W'(lsu_wdata);
            req_d.shifter = lsu_write_shifter;
            req_d.dwhb    = lsu_write_DWHB;
            req_d.owner   = OWN_LSU;
          end else begin
            ifu_req_ready = 1'b1;
            req_d.op_read = 1'b1;
            req_d.addr    = CA_ADDR_W'(ifu_addr);
            req_d.owner   = OWN_IFU;
          end
        end
      end
      ISSUE: begin
        cache_valid = 1'b1;
        if (cache_ready) state_next = WAIT;
      end
      WAIT: begin
        if (cache_out_valid) begin
          state_next = IDLE;
          if (req_q.owner == OWN_LSU) begin
            lsu_resp_valid = 1'b1;
            if (req_q.op_read) lsu_resp_data = cache_data;
          end else begin
            ifu_resp_valid = 1'b1;
            ifu_resp_data  = cache_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req_q        <= '0;
      ignore_count <= '0;
    end else begin
      state <= state_next;
      if (req_load) req_q <= req_d;
      if (cache_out_valid && (state != WAIT) && (ignore_count != 8'hFF)) begin
        ignore_count <= ignore_count + 8'd1;
      end
    end
  end

  // Write address is only meaningful for LSU requests; IFU fetches present 0.
  assign cache_op_read       = req_q.op_read;
  assign cache_read_address  = ADDR_WIDTH'(req_q.addr);
  assign cache_write_address = (req_q.owner == OWN_LSU) ? ADDR_WIDTH'(req_q.addr) : '0;
  assign cache_write_data    = DATA_WIDTH'(req_q.wdata);
  assign cache_write_shifter = req_q.shifter;
  assign cache_write_DWHB    = req_q.dwhb;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter: a cache responder, a transaction-level
// reference model with a scoreboard queue, and directed reset/stray cases.
module tb_cache_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_op_read, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_resp_data;
  logic [7:0]  lsu_write_shifter, lsu_write_DWHB;
  logic        cache_valid, cache_ready, cache_op_read, cache_out_valid;
  logic [63:0] cache_read_address, cache_write_address, cache_write_data, cache_data;
  logic [7:0]  cache_write_shifter, cache_write_DWHB;

  cache_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_op_read(lsu_op_read),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_write_shifter(lsu_write_shifter),
    .lsu_write_DWHB(lsu_write_DWHB), .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .cache_valid(cache_valid), .cache_ready(cache_ready), .cache_op_read(cache_op_read),
    .cache_read_address(cache_read_address), .cache_write_address(cache_write_address),
    .cache_write_data(cache_write_data), .cache_write_shifter(cache_write_shifter),
    .cache_write_DWHB(cache_write_DWHB), .cache_out_valid(cache_out_valid), .cache_data(cache_data)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- cache responder ----------------
  bit          stall_en = 0, stray_req = 0, fix_data_en = 0;
  int unsigned fix_lat = 0;
  logic [63:0] fix_data = '0;

  initial begin
    bit hs;
    int unsigned lat;
    cache_ready = 1'b1; cache_out_valid = 1'b0; cache_data = '0;
    forever begin
      @(negedge clk);
      hs = cache_valid && cache_ready && !reset;
      @(posedge clk); #1;
      if (stray_req) begin
        stray_req = 0;
        cache_out_valid = 1'b1; cache_data = {$urandom, $urandom};
        @(posedge clk); #1;
        cache_out_valid = 1'b0;
      end else if (hs) begin
        lat = (fix_lat != 0) ? fix_lat : $urandom_range(3, 2);
        cache_ready = 1'b0;
        repeat (lat - 1) begin @(posedge clk); #1; end
        cache_out_valid = 1'b1;
        cache_data = fix_data_en ? fix_data : {$urandom, $urandom};
        @(posedge clk); #1;
        cache_out_valid = 1'b0; cache_data = {$urandom, $urandom}; cache_ready = 1'b1;
      end else if (stall_en && $urandom_range(3) == 0) begin
        cache_ready = 1'b0;
        repeat ($urandom_range(5, 1)) begin @(posedge clk); #1; end
        cache_ready = 1'b1;
      end
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct {
    bit          op;
    logic [63:0] raddr, waddr, wdata;
    logic [7:0]  sh, dw;
    bit          lsu;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_stage = 0;   // 0 free, 1 request outstanding to cache, 2 awaiting result
  bit          m_prio = 1;    // 1: LSU wins a tie
  int unsigned m_ign = 0;

  initial begin
    exp_t e;
    int unsigned st;
    bit gr, win_lsu, e_iv, e_lv;
    logic [63:0] e_id, e_ld;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_stage = 0; m_prio = 1; m_ign = 0; sb.delete();
      end else begin
        st = m_stage; gr = 0; win_lsu = 0;
        if (st == 0 && cache_ready && (ifu_req_valid || lsu_req_valid)) begin
          gr = 1;
          win_lsu = (ifu_req_valid && lsu_req_valid) ? m_prio : lsu_req_valid;
          m_prio = !win_lsu;
          if (win_lsu) e = '{lsu_op_read, lsu_addr, lsu_addr, lsu_wdata, lsu_write_shifter, lsu_write_DWHB, 1'b1};
          else         e = '{1'b1, ifu_addr, 64'd0, 64'd0, 8'd0, 8'd0, 1'b0};
          sb.push_back(e);
        end
        check("ifu_req_ready", ifu_req_ready, gr && !win_lsu);
        check("lsu_req_ready", lsu_req_ready, gr && win_lsu);
        check("cache_valid", cache_valid, st == 1);
        if (st == 1 && sb.size() != 0) begin
          e = sb[0];
          check("cache_op_read", cache_op_read, e.op);
          check("cache_read_address", cache_read_address, e.raddr);
          check("cache_write_address", cache_write_address, e.waddr);
          check("cache_write_data", cache_write_data, e.wdata);
          check("cache_write_shifter", cache_write_shifter, e.sh);
          check("cache_write_DWHB", cache_write_DWHB, e.dw);
          if (cache_ready) m_stage = 2;
        end
        e_iv = 0; e_lv = 0; e_id = '0; e_ld = '0;
        if (st == 2 && cache_out_valid && sb.size() != 0) begin
          e = sb.pop_front();
          if (e.lsu) begin e_lv = 1; e_ld = e.op ? cache_data : 64'd0; end
          else       begin e_iv = 1; e_id = cache_data; end
          m_stage = 0;
        end else if (cache_out_valid && st != 2 && m_ign != 255) begin
          m_ign++;
        end
        check("ifu_resp_valid", ifu_resp_valid, e_iv);
        check("ifu_resp_data", ifu_resp_data, e_id);
        check("lsu_resp_valid", lsu_resp_valid, e_lv);
        check("lsu_resp_data", lsu_resp_data, e_ld);
        if (gr) m_stage = 1;
      end
    end
  end

  // ---------------- requester driver ----------------
  int unsigned rate = 0;
  bit ai, al;

  task automatic cyc();
    @(negedge clk);
    ai = ifu_req_valid && ifu_req_ready;
    al = lsu_req_valid && lsu_req_ready;
    @(posedge clk); #1;
    if (ai) ifu_req_valid = 1'b0;
    if (al) lsu_req_valid = 1'b0;
    if (!ifu_req_valid && $urandom_range(99) < rate) begin
      ifu_req_valid = 1'b1; ifu_addr = {$urandom, $urandom};
    end
    if (!lsu_req_valid && $urandom_range(99) < rate) begin
      lsu_req_valid = 1'b1; lsu_op_read = 1'($urandom_range(1));
      lsu_addr = {$urandom, $urandom}; lsu_wdata = {$urandom, $urandom};
      lsu_write_shifter = 8'(8 * $urandom_range(7));
      lsu_write_DWHB = 8'(1 << $urandom_range(3));
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, " cache_valid"}, cache_valid, 0);
    check({tag, " ifu_req_ready"}, ifu_req_ready, 0);
    check({tag, " lsu_req_ready"}, lsu_req_ready, 0);
    check({tag, " ifu_resp_valid"}, ifu_resp_valid, 0);
    check({tag, " lsu_resp_valid"}, lsu_resp_valid, 0);
    check({tag, " cache_read_address"}, cache_read_address, 0);
    check({tag, " cache_write_data"}, cache_write_data, 0);
    check({tag, " cache_op_read"}, cache_op_read, 0);
  endtask

  initial begin
    int unsigned n;
    reset = 1'b0;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_op_read = 0; lsu_addr = '0; lsu_wdata = '0;
    lsu_write_shifter = '0; lsu_write_DWHB = '0;
    #1 reset = 1'b1;
    #2 check_quiet_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // stray result while idle
    stray_req = 1;
    repeat (4) cyc();
    check("ignore_count after stray", dut.ignore_count, 8'd1);

    // IFU read hit
    fix_data_en = 1; fix_data = 64'h1234; fix_lat = 2;
    ifu_req_valid = 1; ifu_addr = 64'h8000_0010;
    repeat (8) cyc();

    // LSU byte store
    fix_lat = 3;
    lsu_req_valid = 1; lsu_op_read = 0; lsu_addr = 64'h8000_0101;
    lsu_wdata = 64'hAB; lsu_write_shifter = 8'd8; lsu_write_DWHB = 8'h01;
    repeat (8) cyc();

    // both requesters held busy, then random traffic with cache stalls
    fix_data_en = 0; fix_lat = 0; rate = 100;
    repeat (30) cyc();
    stall_en = 1; rate = 40;
    repeat (3000) cyc();
    rate = 0; stall_en = 0;
    repeat (20) cyc();

    // reset while waiting for a cache result
    fix_lat = 3;
    ifu_req_valid = 1; ifu_addr = {$urandom, $urandom};
    n = 0;
    while (m_stage != 2 && n < 30) begin cyc(); n++; end
    check("reached wait before reset", m_stage, 2);
    #2 reset = 1'b1;
    #1 check_quiet_outputs("async reset");
    rate = 100;
    repeat (3) cyc();
    reset = 1'b0;
    n = 0; ai = 0; al = 0;
    while (!ai && !al && n < 30) begin cyc(); n++; end
    check("first grant after reset {ifu,lsu}", {ai, al}, 2'b01);

    fix_lat = 0; rate = 40;
    repeat (300) cyc();
    rate = 0;
    repeat (20) cyc();
    check("ignore_count final", dut.ignore_count, m_ign);
    check("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
